// File: rtl/mdu_if.sv
// Handshake and result bundle between the pipeline control and the
// iterative multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One bit per cycle on operand magnitudes; sign correction is applied
// once, in the COMMIT cycle, when HI/LO are loaded.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, a_neg_q, a_neg_d, bzero_q, bzero_d;

    logic               sa_s, sb_s, div_ok_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    // Operand magnitudes, per-iteration arithmetic and commit-time sign fixes.
    always_comb begin
        sa_s        = bus.a[WIDTH-1] & ~bus.op[0];
        sb_s        = bus.b[WIDTH-1] & ~bus.op[0];
        mag_a_s     = sa_s ? (WIDTH'(0) - bus.a) : bus.a;
        mag_b_s     = sb_s ? (WIDTH'(0) - bus.b) : bus.b;
        // Multiply: upper half accumulates, multiplier bits shift out at the bottom.
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        // Divide: partial remainder in the upper half, dividend/quotient below.
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        div_ok_s    = ~div_diff_s[WIDTH];
        prod_fix_s  = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        quo_fix_s   = neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix_s   = a_neg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH])
                              : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control state register with immediate asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: starts are only honoured in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_RUN : S_IDLE;
            S_RUN:    state_d = (cnt_q == CNT_LAST) ? S_COMMIT : S_RUN;
            S_COMMIT: state_d = S_DONE;
            S_DONE:   state_d = bus.start ? S_RUN : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs derived from the upcoming state so they register cleanly.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == S_RUN) || (state_d == S_COMMIT)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath: operand capture, iteration and HI/LO commit.
    always_comb begin
        op_d    = op_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        bzero_d = bzero_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    neg_d   = sa_s ^ sb_s;
                    a_neg_d = sa_s;
                    bzero_d = (bus.b == WIDTH'(0));
                    opb_d   = bus.op[1] ? mag_b_s : mag_a_s;
                    acc_d   = {WIDTH'(0), (bus.op[1] ? mag_a_s : mag_b_s)};
                    cnt_d   = CW'(0);
                    dbz_d   = 1'b0;
                end else begin
                    dbz_d   = dbz_q;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    acc_d = {(div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ok_s};
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
            end
            S_COMMIT: begin
                if (op_q[1]) begin
                    // A zero divisor leaves the dividend as remainder; the
                    // quotient is forced to all ones regardless of sign.
                    hi_d  = rem_fix_s;
                    lo_d  = bzero_q ? {WIDTH{1'b1}} : quo_fix_s;
                    dbz_d = bzero_q;
                end else begin
                    hi_d  = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d  = prod_fix_s[WIDTH-1:0];
                    dbz_d = 1'b0;
                end
            end
            default: begin
                cnt_d = CW'(0);
            end
        endcase
    end

    // Datapath and status registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            bzero_q <= bzero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed, table-driven bench for the iterative multiply/divide unit.
module tb_mdu_iterative;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    vec_t vecs [13];

    mdu_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Present an operation just after an edge; the next edge is E0.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk("busy_at_e0", {31'd0, bus.busy}, 32'd1);
        chk("dbz_clear_at_e0", {31'd0, bus.div_by_zero}, 32'd0);
    endtask

    // Count edges after E0 until done; optionally inject an ignored start.
    task automatic wait_done(input int ign_at, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == ign_at) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (k == 5) begin
                chk("hi_hold_run", bus.hi, prev_hi);
                chk("lo_hold_run", bus.lo, prev_lo);
            end
            if (k <= 32) begin
                chk("busy_run", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.done) begin
                lat = k;
                chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
                break;
            end
        end
        chk("latency", lat, 32'd33);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] hi,
                                input logic [W-1:0] lo, input logic dbz);
        chk({nm, "_hi"}, bus.hi, hi);
        chk({nm, "_lo"}, bus.lo, lo);
        chk({nm, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, dbz});
        prev_hi = hi;
        prev_lo = lo;
    endtask

    initial begin
        int lat;
        total = 0;
        bad   = 0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        //          op     a             b             hi            lo            dbz
        vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[9]  = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[11] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[12] = '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, each followed by two idle cycles.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, lat);
            check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dbz);
            for (int j = 0; j < 2; j++) begin
                @(posedge clk);
                #1;
                chk("idle_done_low", {31'd0, bus.done}, 32'd0);
                chk("idle_busy_low", {31'd0, bus.busy}, 32'd0);
                chk("idle_dbz_hold", {31'd0, bus.div_by_zero}, {31'd0, vecs[i].dbz});
                chk("idle_lo_hold", bus.lo, vecs[i].lo);
            end
        end

        // Start while busy is ignored, then a back-to-back start from DONE.
        issue(2'd3, 32'd100, 32'd7);
        wait_done(10, lat);
        check_result("ign_divu", 32'd2, 32'd14, 1'b0);
        issue(2'd1, 32'd9, 32'd9);
        wait_done(0, lat);
        check_result("b2b_multu", 32'd0, 32'h51, 1'b0);

        // Asynchronous reset in the middle of an operation.
        issue(2'd1, 32'h1234, 32'h10);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        end
        issue(2'd1, 32'h1234, 32'h10);
        wait_done(0, lat);
        check_result("post_rst_multu", 32'd0, 32'h12340, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Iterative multiply/divide unit for the 32-bit MIPS datapath. It executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the architectural HI/LO result registers. HI/LO feed the MFHI/MFLO path into the register-file write-back. It sits directly upstream of the enable-gated pipeline/result registers. Its busy flag drives the pipeline stall logic, so that no HI/LO read occurs while an operation is in flight.

Parameters:
WIDTH, 32, operand and result-half width in bits. Iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an operation; sampled on the clk rising edge
op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  operation in flight; further starts are ignored
done  output  1  one-cycle pulse: hi/lo hold the new result
hi  output  WIDTH  HI register: product upper half, or remainder
lo  output  WIDTH  LO register: product lower half, or quotient
div_by_zero  output  1  last accepted op was a DIV/DIVU with b==0

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset, asserted at any time including mid-operation, takes effect immediately:
  - state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0.
  - All internal accumulators and the counter are cleared. The aborted operation is lost.
- States and transitions:
  - IDLE --start=1--> RUN
  - RUN --WIDTH iterations complete--> COMMIT
  - COMMIT --> DONE
  - DONE --start=1--> RUN
  - DONE --start=0--> IDLE
- Accept rule:
  - start is accepted only in IDLE or DONE. Call the accepting edge E0.
  - At E0: latch op, take operand magnitudes (signed ops only), latch sign flags, clear counter, clear div_by_zero.
  - busy=1 from E0.
- start while busy (RUN or COMMIT) is ignored: no operand capture and no effect on the running result.
- RUN: one iteration per edge, E1..E_WIDTH. Counter runs 0..WIDTH-1.
  - Multiply: unsigned shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- COMMIT, at edge E_{WIDTH+1}: apply sign correction and load hi/lo.
  - state -> DONE, busy=0, done=1 for exactly one cycle.
  - Latency: done is high in the cycle after E_{WIDTH+1}, i.e. the 33rd edge after E0 for WIDTH=32.
- hi/lo change only at COMMIT or reset. They hold their values in all other states, including during RUN (the old result stays readable).
- Sign rules:
  - MULT: the 2*WIDTH product is negated if the operand signs differ. hi=upper half, lo=lower half.
  - DIV: quotient is negated if the signs differ. Remainder takes the sign of the dividend. lo=quotient, hi=remainder.
  - Unsigned ops: no correction.
- Boundary cases:
  - Signed DIV of most-negative / -1: lo=0x80000000, hi=0 (wraps; no trap).
  - b==0 on DIV or DIVU: full latency still applies. hi=original a, lo=all ones, div_by_zero=1 at COMMIT.
  - div_by_zero stays set until the next accepted start.
  - Operand inputs may change freely after E0 without affecting the result.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done high exactly in the cycle after the 33rd edge following E0. busy high during edges E0..E_32.
2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 7/0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1. Next MULTU 2*3 -> div_by_zero clears at its E0, lo=6.
5. Start DIVU 100/7, then pulse start with MULTU 9*9 at cycle 10 -> pulse ignored, result lo=14/hi=2. Start MULTU 9*9 during the DONE cycle -> accepted back-to-back, lo=0x51, hi=0.
6. Start MULTU 0x1234*0x10, drop rst_n mid-cycle at iteration 10 -> busy, done, hi, lo go to 0 immediately without a clock edge. After release, MULTU 0x1234*0x10 -> lo=0x12340, hi=0.
